monitor_rango: RTL and testbench
================================

MONITOR_RANGO -- requirements
Module: monitor_rango

Interface
REQ-001 Parameter ANCHO, default 5: sample and limit width, two's complement signed, legal range 2..16.
REQ-002 Parameter UMBRAL, default 3: consecutive samples required to enter or leave alarm, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-005 cargarLimites  input  1  strobe: capture limiteInferior/limiteSuperior/inclusivo this cycle.
REQ-006 limiteInferior  input  ANCHO  signed lower bound.
REQ-007 limiteSuperior  input  ANCHO  signed upper bound.
REQ-008 inclusivo  input  1  1 = bounds count as inside, 0 = strict.
REQ-009 numeroValido  input  1  sample present on numero.
REQ-010 numero  input  ANCHO  signed sample.
REQ-011 listo  output  1  sample accepted when numeroValido && listo.
REQ-012 resultadoValido  output  1  one-cycle pulse, seEncuentraDentro updated.
REQ-013 seEncuentraDentro  output  1  registered in-range result of last accepted sample.
REQ-014 alarma  output  1  high in state ALERTA.
REQ-015 limitesInvalidos  output  1  sticky: last load had limiteInferior > limiteSuperior.
REQ-016 cuentaDentro, cuentaFuera  output  16 each  accepted-sample counters (see Configuration).

Function
REQ-017 All comparisons SHALL be signed over full ANCHO bits; no sign-magnitude conversion.
REQ-018 Inside = (L <= n <= S) when stored inclusivo=1, (L < n < S) when 0, using stored limits.
REQ-019 States: ESPERA, NORMAL, ALERTA; ESPERA after reset.
REQ-020 listo = 0 in ESPERA and in any cycle with cargarLimites=1; otherwise 1.
REQ-021 Load with L <= S: store limits/mode, limitesInvalidos<=0, run counter<=0, next state NORMAL (from any state).
REQ-022 Load with L > S: limits not stored, limitesInvalidos<=1, run counter<=0, next state ESPERA, alarma drops next cycle.
REQ-023 Load and numeroValido in same cycle: load wins, sample dropped, no resultadoValido.
REQ-024 Accepted sample: seEncuentraDentro and resultadoValido=1 on next edge (latency 1); resultadoValido=0 otherwise.
REQ-025 NORMAL: outside sample increments run counter, inside clears it; counter reaching UMBRAL -> ALERTA, counter<=0.
REQ-026 ALERTA: inside sample increments run counter, outside clears it; reaching UMBRAL -> NORMAL, counter<=0.
REQ-027 alarma SHALL assert in the same cycle resultadoValido reports the UMBRAL-th outside sample (registered with state).
REQ-028 Back-to-back samples every cycle SHALL be accepted with no bubbles.

Reset
REQ-029 reset SHALL override all inputs including cargarLimites.
REQ-030 Reset values: state ESPERA, stored limits 0, inclusivo 1, run counter 0, seEncuentraDentro 0, resultadoValido 0, alarma 0, limitesInvalidos 0, cuentaDentro 0, cuentaFuera 0.
REQ-031 Reset mid-alarm SHALL clear alarma on the following edge; new load required before samples accepted.

Configuration
REQ-032 Macro MONITOR_RANGO_CONTADORES_EN defined: cuentaDentro/cuentaFuera increment per accepted inside/outside sample, saturate at 16'hFFFF, cleared by reset and by valid load.
REQ-033 Macro undefined: counters not built, cuentaDentro and cuentaFuera tied to 0; all other behaviour identical.

Verification
REQ-034 ANCHO=5: load L=-5 (5'b11011), S=3, inclusivo=1; samples -5,3,-6,4 -> seEncuentraDentro 1,1,0,0, each one cycle after acceptance.
REQ-035 Same limits, inclusivo=0: samples -5,0,3 -> 0,1,0.
REQ-036 UMBRAL=3, L=-2, S=2: samples 7,7,7 -> alarma rises with third result; then 0,0,0 -> alarma falls with sixth result; 7,0,7 gives no alarm.
REQ-037 Load L=4, S=-4 -> limitesInvalidos=1, listo=0, samples ignored (no resultadoValido); reload L=-4,S=4 -> limitesInvalidos=0, listo=1.
REQ-038 cargarLimites and numeroValido both high -> no resultadoValido next cycle; reset asserted during ALERTA -> alarma=0, state ESPERA, counters 0.
REQ-039 With MONITOR_RANGO_CONTADORES_EN: 10 inside, 4 outside samples -> cuentaDentro=10, cuentaFuera=4; without macro both read 0.

Source files
------------

// File: rtl/monitor_rango.sv
// Signed range monitor with inside/outside debounce (NORMAL <-> ALERTA after UMBRAL consecutive samples).
// Define MONITOR_RANGO_CONTADORES_EN to build the saturating inside/outside sample counters.
module monitor_rango #(
    parameter int ANCHO  = 5,
    parameter int UMBRAL = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cargarLimites,
    input  logic signed [ANCHO-1:0] limiteInferior,
    input  logic signed [ANCHO-1:0] limiteSuperior,
    input  logic                    inclusivo,
    input  logic                    numeroValido,
    input  logic signed [ANCHO-1:0] numero,
    output logic                    listo,
    output logic                    resultadoValido,
    output logic                    seEncuentraDentro,
    output logic                    alarma,
    output logic                    limitesInvalidos,
    output logic [15:0]             cuentaDentro,
    output logic [15:0]             cuentaFuera
);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        NORMAL = 2'd1,
        ALERTA = 2'd2
    } Estado;

    localparam logic [3:0] umbralC = 4'(UMBRAL);

    Estado                    estado;
    logic signed [ANCHO-1:0]  limInf;
    logic signed [ANCHO-1:0]  limSup;
    logic                     inclusivoReg;
    logic [3:0]               cuentaRacha;

    logic limitesOk;
    logic cargaValida;
    logic aceptado;
    logic dentro;
    logic avanzaRacha;
    logic finRacha;

    assign limitesOk   = (limiteInferior <= limiteSuperior);
    assign cargaValida = cargarLimites && limitesOk;

    // A load always steals the cycle, so a sample offered alongside it is never accepted.
    assign listo    = (estado != ESPERA) && !cargarLimites;
    assign aceptado = numeroValido && listo;

    assign dentro = inclusivoReg ? ((numero >= limInf) && (numero <= limSup))
                                 : ((numero >  limInf) && (numero <  limSup));

    // The run counter only advances on samples that argue for leaving the current state.
    assign avanzaRacha = ((estado == NORMAL) && !dentro) || ((estado == ALERTA) && dentro);
    assign finRacha    = (cuentaRacha + 4'd1) == umbralC;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado            <= ESPERA;
            limInf            <= '0;
            limSup            <= '0;
            inclusivoReg      <= 1'b1;
            cuentaRacha       <= '0;
            seEncuentraDentro <= 1'b0;
            resultadoValido   <= 1'b0;
            alarma            <= 1'b0;
            limitesInvalidos  <= 1'b0;
        end else begin
            resultadoValido <= 1'b0;
            if (cargarLimites) begin
                cuentaRacha <= '0;
                alarma      <= 1'b0;
                if (limitesOk) begin
                    limInf           <= limiteInferior;
                    limSup           <= limiteSuperior;
                    inclusivoReg     <= inclusivo;
                    limitesInvalidos <= 1'b0;
                    estado           <= NORMAL;
                end else begin
                    limitesInvalidos <= 1'b1;
                    estado           <= ESPERA;
                end
            end else if (aceptado) begin
                resultadoValido   <= 1'b1;
                seEncuentraDentro <= dentro;
                if (!avanzaRacha) begin
                    cuentaRacha <= '0;
                end else if (finRacha) begin
                    cuentaRacha <= '0;
                    if (estado == NORMAL) begin
                        estado <= ALERTA;
                        alarma <= 1'b1;
                    end else begin
                        estado <= NORMAL;
                        alarma <= 1'b0;
                    end
                end else begin
                    cuentaRacha <= cuentaRacha + 4'd1;
                end
            end
        end
    end

`ifdef MONITOR_RANGO_CONTADORES_EN
    // Counters saturate instead of wrapping so a long run never looks like a fresh start.
    always_ff @(posedge clk) begin
        if (reset || cargaValida) begin
            cuentaDentro <= '0;
            cuentaFuera  <= '0;
        end else if (aceptado) begin
            if (dentro && (cuentaDentro != 16'hFFFF)) begin
                cuentaDentro <= cuentaDentro + 16'd1;
            end
            if (!dentro && (cuentaFuera != 16'hFFFF)) begin
                cuentaFuera <= cuentaFuera + 16'd1;
            end
        end
    end
`else
    logic unusedCarga;
    assign unusedCarga  = cargaValida;
    assign cuentaDentro = 16'd0;
    assign cuentaFuera  = 16'd0;
`endif

endmodule

// File: tb/tb_monitor_rango.sv
// Scoreboard bench for monitor_rango (ANCHO=5, UMBRAL=3); counter checks follow MONITOR_RANGO_CONTADORES_EN.
module tb_monitor_rango;

    localparam int ANCHO = 5;

    logic                    clk;
    logic                    reset;
    logic                    cargarLimites;
    logic signed [ANCHO-1:0] limiteInferior;
    logic signed [ANCHO-1:0] limiteSuperior;
    logic                    inclusivo;
    logic                    numeroValido;
    logic signed [ANCHO-1:0] numero;
    logic                    listo;
    logic                    resultadoValido;
    logic                    seEncuentraDentro;
    logic                    alarma;
    logic                    limitesInvalidos;
    logic [15:0]             cuentaDentro;
    logic [15:0]             cuentaFuera;

    typedef struct {
        logic dentro;
        logic alarma;
    } Esperado;

    Esperado cola[$];
    int      assertCount;
    int      failCount;
    int      expDentroCnt;
    int      expFueraCnt;

    monitor_rango #(.ANCHO(ANCHO), .UMBRAL(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .cargarLimites    (cargarLimites),
        .limiteInferior   (limiteInferior),
        .limiteSuperior   (limiteSuperior),
        .inclusivo        (inclusivo),
        .numeroValido     (numeroValido),
        .numero           (numero),
        .listo            (listo),
        .resultadoValido  (resultadoValido),
        .seEncuentraDentro(seEncuentraDentro),
        .alarma           (alarma),
        .limitesInvalidos (limitesInvalidos),
        .cuentaDentro     (cuentaDentro),
        .cuentaFuera      (cuentaFuera)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Results are popped in the half cycle after the edge that produced them.
    always @(negedge clk) begin
        if (resultadoValido) begin
            if (cola.size() > 0) begin
                Esperado e;
                e = cola.pop_front();
                checkOutput("seEncuentraDentro", 32'(seEncuentraDentro), 32'(e.dentro));
                checkOutput("alarmaWithResult", 32'(alarma), 32'(e.alarma));
            end else begin
                checkOutput("spuriousResult", 32'(resultadoValido), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic signed [ANCHO-1:0] n, input logic expDentro, input logic expAlarma);
        Esperado e;
        @(negedge clk);
        cargarLimites = 1'b0;
        numeroValido  = 1'b1;
        numero        = n;
        e.dentro = expDentro;
        e.alarma = expAlarma;
        cola.push_back(e);
        if (expDentro) expDentroCnt++;
        else           expFueraCnt++;
    endtask

    task automatic loadLimits(input logic signed [ANCHO-1:0] l, input logic signed [ANCHO-1:0] s, input logic inc);
        @(negedge clk);
        cargarLimites  = 1'b1;
        numeroValido   = 1'b0;
        limiteInferior = l;
        limiteSuperior = s;
        inclusivo      = inc;
        if (l <= s) begin
            expDentroCnt = 0;
            expFueraCnt  = 0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cargarLimites = 1'b0;
        numeroValido  = 1'b0;
    endtask

    task automatic ignoredSample(input logic signed [ANCHO-1:0] n);
        @(negedge clk);
        cargarLimites = 1'b0;
        numeroValido  = 1'b1;
        numero        = n;
        #1 checkOutput("listoLowWhenIgnored", 32'(listo), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount    = 0;
        failCount      = 0;
        expDentroCnt   = 0;
        expFueraCnt    = 0;
        reset          = 1'b1;
        cargarLimites  = 1'b0;
        limiteInferior = '0;
        limiteSuperior = '0;
        inclusivo      = 1'b0;
        numeroValido   = 1'b0;
        numero         = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetAlarma", 32'(alarma), 32'd0);
        checkOutput("resetResultadoValido", 32'(resultadoValido), 32'd0);
        checkOutput("resetDentro", 32'(seEncuentraDentro), 32'd0);
        checkOutput("resetLimInvalidos", 32'(limitesInvalidos), 32'd0);
        checkOutput("resetListo", 32'(listo), 32'd0);
        checkOutput("resetCuentaDentro", 32'(cuentaDentro), 32'd0);
        checkOutput("resetCuentaFuera", 32'(cuentaFuera), 32'd0);
        reset = 1'b0;

        // Inclusive bounds [-5, 3]
        loadLimits(-5, 3, 1'b1);
        applyStimulus(-5, 1'b1, 1'b0);
        applyStimulus(3, 1'b1, 1'b0);
        applyStimulus(-6, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);
        idle();

        // Strict bounds (-5, 3)
        loadLimits(-5, 3, 1'b0);
        applyStimulus(-5, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        idle();

        // Debounce into and out of ALERTA, then a broken run
        loadLimits(-2, 2, 1'b1);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        idle();

        // Invalid load while in ALERTA
        loadLimits(-4, 4, 1'b1);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b1);
        loadLimits(4, -4, 1'b1);
        idle();
        #1;
        checkOutput("alarmaDropsOnBadLoad", 32'(alarma), 32'd0);
        checkOutput("limInvalidosSet", 32'(limitesInvalidos), 32'd1);
        ignoredSample(0);
        ignoredSample(1);
        idle();
        #1 checkOutput("noResultWhileInvalid", 32'(resultadoValido), 32'd0);

        // Load and sample together: load wins
        @(negedge clk);
        cargarLimites  = 1'b1;
        limiteInferior = -4;
        limiteSuperior = 4;
        inclusivo      = 1'b1;
        numeroValido   = 1'b1;
        numero         = 0;
        expDentroCnt   = 0;
        expFueraCnt    = 0;
        #1 checkOutput("listoLowDuringLoad", 32'(listo), 32'd0);
        idle();
        #1;
        checkOutput("noResultOnLoadCollision", 32'(resultadoValido), 32'd0);
        checkOutput("limInvalidosCleared", 32'(limitesInvalidos), 32'd0);
        checkOutput("listoAfterReload", 32'(listo), 32'd1);

        // Reset mid-alarm overrides a simultaneous load and sample
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b1);
        @(negedge clk);
        reset         = 1'b1;
        cargarLimites = 1'b1;
        numeroValido  = 1'b1;
        numero        = 7;
        @(negedge clk);
        reset         = 1'b0;
        cargarLimites = 1'b0;
        numeroValido  = 1'b0;
        expDentroCnt  = 0;
        expFueraCnt   = 0;
        #1;
        checkOutput("alarmaClearedByReset", 32'(alarma), 32'd0);
        checkOutput("listoLowAfterReset", 32'(listo), 32'd0);
        checkOutput("noResultDuringReset", 32'(resultadoValido), 32'd0);
        checkOutput("cuentaDentroAfterReset", 32'(cuentaDentro), 32'd0);
        checkOutput("cuentaFueraAfterReset", 32'(cuentaFuera), 32'd0);
        ignoredSample(0);
        idle();
        #1 checkOutput("noResultAfterReset", 32'(resultadoValido), 32'd0);

        // Counter run: 10 inside, 4 outside, back to back
        loadLimits(-4, 4, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b1);
        applyStimulus(-8, 1'b0, 1'b1);
        idle();
        idle();
        #1;
`ifdef MONITOR_RANGO_CONTADORES_EN
        checkOutput("cuentaDentro", 32'(cuentaDentro), 32'(expDentroCnt));
        checkOutput("cuentaFuera", 32'(cuentaFuera), 32'(expFueraCnt));
`else
        checkOutput("cuentaDentroTied", 32'(cuentaDentro), 32'd0);
        checkOutput("cuentaFueraTied", 32'(cuentaFuera), 32'd0);
`endif
        checkOutput("scoreboardDrained", 32'(cola.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
